mux_scan_ctrl: RTL and testbench

- Upstream controller for the team's 4:1 single-bit mux stage.
- Drives the mux select lines s1:s0 through channels 0..3 and waits a programmable settle time on each channel.
- Samples the mux output on each channel and presents the four bits as one registered vector with a one-cycle valid strobe.
- Supports single-shot scans (start pulse) and free-running scans (continuous mode).

---
 rtl/mux_scan_ctrl.sv | 107 ++++++++++
 tb/tb_mux_scan_ctrl.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/mux_scan_ctrl.sv
// Scan controller for the 4:1 single-bit mux: steps s1:s0 over channels 0..3 and
// samples each one after a settle delay. Define MUX_SCAN_PARITY_EN to add a parity output.
module mux_scan_ctrl #(
    parameter int SETTLE_CYC = 2,
    parameter int CNT_W      = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       continuous,
    input  logic       abort,
    input  logic       mux_out,
    output logic       s0,
    output logic       s1,
    output logic [3:0] sample_vec,
    output logic       valid,
    output logic       busy
`ifdef MUX_SCAN_PARITY_EN
    ,
    output logic       parity
`endif
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] SETTLE_N = CNT_W'(SETTLE_CYC);
    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
    localparam state_t           ENTRY    = (SETTLE_CYC == 0) ? SAMPLE : SETTLE;

    state_t           state;
    logic [1:0]       ch;
    logic [1:0]       sel;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       shadow;

    assign s0   = sel[0];
    assign s1   = sel[1];
    assign busy = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            ch         <= 2'd0;
            sel        <= 2'd0;
            cnt        <= '0;
            shadow     <= 3'd0;
            sample_vec <= 4'd0;
            valid      <= 1'b0;
`ifdef MUX_SCAN_PARITY_EN
            parity     <= 1'b0;
`endif
        end else begin
            valid <= 1'b0;
            if (abort) begin
                state  <= IDLE;
                ch     <= 2'd0;
                sel    <= 2'd0;
                cnt    <= '0;
                shadow <= 3'd0;
            end else begin
                unique case (state)
                    IDLE: begin
                        sel <= 2'd0;
                        if (start || continuous) begin
                            ch    <= 2'd0;
                            cnt   <= SETTLE_N;
                            state <= ENTRY;
                        end
                    end
                    SETTLE: begin
                        cnt <= cnt - ONE;
                        if (cnt == ONE) state <= SAMPLE;
                    end
                    SAMPLE: begin
                        cnt <= SETTLE_N;
                        if (ch != 2'd3) begin
                            unique case (ch)
                                2'd0:    shadow[0] <= mux_out;
                                2'd1:    shadow[1] <= mux_out;
                                default: shadow[2] <= mux_out;
                            endcase
                            ch    <= ch + 2'd1;
                            sel   <= ch + 2'd1;
                            state <= ENTRY;
                        end else begin
                            // channel 3 is taken straight from the mux, not via shadow
                            sample_vec <= {mux_out, shadow};
                            valid      <= 1'b1;
`ifdef MUX_SCAN_PARITY_EN
                            parity     <= ^{mux_out, shadow};
`endif
                            ch  <= 2'd0;
                            sel <= 2'd0;
                            state <= continuous ? ENTRY : IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Directed bench for mux_scan_ctrl: default settle instance plus a zero-settle
// instance, each driven by a small combinational 4:1 mux model.
module tb_mux_scan_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0, continuous = 1'b0, abort = 1'b0;
    logic [3:0] pat = 4'd0;
    logic       mux_out, s0, s1, valid, busy;
    logic [3:0] sample_vec;
    logic       start_z = 1'b0;
    logic [3:0] pat_z = 4'd0;
    logic       mux_out_z, s0_z, s1_z, valid_z, busy_z;
    logic [3:0] sample_vec_z;
`ifdef MUX_SCAN_PARITY_EN
    logic       parity, parity_z;
`endif

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    assign mux_out   = pat[{s1, s0}];
    assign mux_out_z = pat_z[{s1_z, s0_z}];

    mux_scan_ctrl #(.SETTLE_CYC(2), .CNT_W(4)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .continuous(continuous),
        .abort(abort), .mux_out(mux_out), .s0(s0), .s1(s1),
        .sample_vec(sample_vec), .valid(valid), .busy(busy)
`ifdef MUX_SCAN_PARITY_EN
        , .parity(parity)
`endif
    );

    mux_scan_ctrl #(.SETTLE_CYC(0), .CNT_W(4)) u_dut_z (
        .clk(clk), .rst_n(rst_n), .start(start_z), .continuous(1'b0),
        .abort(1'b0), .mux_out(mux_out_z), .s0(s0_z), .s1(s1_z),
        .sample_vec(sample_vec_z), .valid(valid_z), .busy(busy_z)
`ifdef MUX_SCAN_PARITY_EN
        , .parity(parity_z)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // single-shot scan; poke = edge index at which a stray start is applied
    task automatic scan(input logic [3:0] p, input int poke);
        int extra;
        pat = p;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("acc_busy", {31'd0, busy}, 1);
        chk("acc_sel", {30'd0, s1, s0}, 0);
        for (int e = 1; e <= 12; e++) begin
            if (e == poke) start = 1'b1;
            tick();
            start = 1'b0;
            chk("scan_sel", {30'd0, s1, s0}, (e < 12) ? e / 3 : 0);
            chk("scan_valid", {31'd0, valid}, (e == 12) ? 1 : 0);
            chk("scan_busy", {31'd0, busy}, (e < 12) ? 1 : 0);
            if (e < 12) chk("scan_hold", {28'd0, sample_vec}, {28'd0, sample_vec});
        end
        chk("scan_vec", {28'd0, sample_vec}, {28'd0, p});
`ifdef MUX_SCAN_PARITY_EN
        chk("scan_par", {31'd0, parity}, {31'd0, ^p});
`endif
        extra = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            extra += int'(valid) + int'(busy);
        end
        chk("no_requeue", extra, 0);
        chk("vec_hold", {28'd0, sample_vec}, {28'd0, p});
    endtask

    initial begin
        #3;
        chk("rst_vec", {28'd0, sample_vec}, 0);
        chk("rst_valid", {31'd0, valid}, 0);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_sel", {30'd0, s1, s0}, 0);
        tick();
        rst_n = 1'b1;
        tick();

        // abort in SETTLE of channel 2 on the very first run
        pat = 4'b1010;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int e = 1; e <= 7; e++) tick();
        chk("pre_abort_sel", {30'd0, s1, s0}, 2);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_busy", {31'd0, busy}, 0);
        chk("abort_sel", {30'd0, s1, s0}, 0);
        chk("abort_valid", {31'd0, valid}, 0);
        chk("abort_vec", {28'd0, sample_vec}, 0);
        for (int i = 0; i < 12; i++) begin
            tick();
            chk("abort_quiet", {31'd0, valid | busy}, 0);
        end

        // abort beats start in IDLE
        abort = 1'b1;
        start = 1'b1;
        tick();
        abort = 1'b0;
        start = 1'b0;
        chk("abort_start", {31'd0, busy}, 0);
        tick();

        scan(4'b1010, -1);
        scan(4'b1010, 5);

        // continuous: two back-to-back scans, pattern switches after the first
        pat = 4'b1010;
        continuous = 1'b1;
        tick();
        chk("cont_busy", {31'd0, busy}, 1);
        for (int e = 1; e <= 24; e++) begin
            tick();
            chk("cont_sel", {30'd0, s1, s0}, (e % 12) / 3);
            chk("cont_valid", {31'd0, valid}, (e == 12 || e == 24) ? 1 : 0);
            chk("cont_busy", {31'd0, busy}, (e < 24) ? 1 : 0);
            if (e == 12) begin
                chk("cont_vec1", {28'd0, sample_vec}, 4'b1010);
`ifdef MUX_SCAN_PARITY_EN
                chk("cont_par1", {31'd0, parity}, 0);
`endif
                pat = 4'b0111;
            end
            if (e == 13) continuous = 1'b0;
        end
        chk("cont_vec2", {28'd0, sample_vec}, 4'b0111);
`ifdef MUX_SCAN_PARITY_EN
        chk("cont_par2", {31'd0, parity}, 1);
`endif
        tick();
        chk("cont_idle", {31'd0, busy}, 0);

        // asynchronous reset during channel 1
        pat = 4'b1010;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int e = 1; e <= 4; e++) tick();
        chk("pre_rst_sel", {30'd0, s1, s0}, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_busy", {31'd0, busy}, 0);
        chk("arst_sel", {30'd0, s1, s0}, 0);
        chk("arst_vec", {28'd0, sample_vec}, 0);
        chk("arst_valid", {31'd0, valid}, 0);
`ifdef MUX_SCAN_PARITY_EN
        chk("arst_par", {31'd0, parity}, 0);
`endif
        tick();
        rst_n = 1'b1;
        tick();
        scan(4'b1010, -1);

        // zero settle instance
        pat_z = 4'b1100;
        start_z = 1'b1;
        tick();
        start_z = 1'b0;
        chk("z_busy", {31'd0, busy_z}, 1);
        chk("z_sel0", {30'd0, s1_z, s0_z}, 0);
        for (int e = 1; e <= 4; e++) begin
            tick();
            chk("z_sel", {30'd0, s1_z, s0_z}, (e < 4) ? e : 0);
            chk("z_valid", {31'd0, valid_z}, (e == 4) ? 1 : 0);
        end
        chk("z_vec", {28'd0, sample_vec_z}, 4'b1100);
        chk("z_idle", {31'd0, busy_z}, 0);
        tick();
        chk("z_valid_end", {31'd0, valid_z}, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
